pzhsbus_slicer: RTL and testbench

PZHSBUS_SLICER -- requirements
Module: pzhsbus_slicer

---
 rtl/pzhsbus_slicer_if.sv | 12 +
 rtl/pzhsbus_slicer.sv | 135 +++++++++++++
 tb/tb_pzhsbus_slicer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pzhsbus_slicer_if.sv
// pzhsbus_if: valid/ready/payload handshake channel.
// Ports (modports): master drives valid+payload and samples ready;
// slave samples valid+payload and drives ready.
interface pzhsbus_if #(
  parameter int PAYLOAD_WIDTH = 32
);
  logic                     valid;
  logic                     ready;
  logic [PAYLOAD_WIDTH-1:0] payload;
  modport master(output valid, output payload, input ready);
  modport slave(input valid, input payload, output ready);
endinterface

// File: rtl/pzhsbus_slicer.sv
// pzhsbus_slicer: cascade of STAGES register slices (FORWARD, BACKWARD or FULL) on a pzhsbus channel.
// Ports: i_clk clock; i_rst_n async active-low reset; slave_if upstream channel;
// master_if downstream channel; o_empty high when no stage holds data.
module pzhsbus_slicer_stage #(
  parameter int    W    = 32,
  parameter string MODE = "FULL"
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         s_valid,
  input  logic [W-1:0] s_payload,
  output logic         s_ready,
  output logic         m_valid,
  output logic [W-1:0] m_payload,
  input  logic         m_ready,
  output logic         empty
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  logic push;
  assign push = s_valid && s_ready;
  if (MODE == "FORWARD") begin : g_fwd
    logic         valid_q;
    logic [W-1:0] data_q;
    assign s_ready   = !valid_q || m_ready;
    assign m_valid   = valid_q;
    assign m_payload = data_q;
    assign empty     = !valid_q;
    always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) valid_q <= 1'b0;
      else if (s_ready) valid_q <= s_valid;
    always_ff @(posedge i_clk)
      if (push) data_q <= s_payload;
  end else if (MODE == "BACKWARD") begin : g_bwd
    logic         skid_valid;
    logic [W-1:0] skid_data;
    // ready is the inverted skid flop, so it is registered by construction
    assign s_ready   = !skid_valid;
    assign m_valid   = s_valid || skid_valid;
    assign m_payload = skid_valid ? skid_data : s_payload;
    assign empty     = !skid_valid;
    always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) skid_valid <= 1'b0;
      else if (push && !m_ready) skid_valid <= 1'b1;
      else if (m_ready) skid_valid <= 1'b0;
    always_ff @(posedge i_clk)
      if (push && !m_ready) skid_data <= s_payload;
  end else begin : g_full
    state_t       state, state_n;
    logic         rd_ptr, wr_ptr, ready_q, valid_q, pop;
    logic [W-1:0] mem [2];
    assign pop       = valid_q && m_ready;
    assign s_ready   = ready_q;
    assign m_valid   = valid_q;
    assign m_payload = mem[rd_ptr];
    assign empty     = !valid_q;
    always_comb
      state_n = (state == EMPTY) ? (push ? ONE : EMPTY) :
                (state == ONE)   ? ((push && !pop) ? TWO : (pop && !push) ? EMPTY : ONE) :
                                   (pop ? ONE : TWO);
    // ready/valid flops are loaded from the next state so the outputs come straight from flops
    always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
        state   <= EMPTY;
        rd_ptr  <= 1'b0;
        wr_ptr  <= 1'b0;
        ready_q <= 1'b1;
        valid_q <= 1'b0;
      end else begin
        state   <= state_n;
        rd_ptr  <= rd_ptr ^ pop;
        wr_ptr  <= wr_ptr ^ push;
        ready_q <= state_n != TWO;
        valid_q <= state_n != EMPTY;
      end
    always_ff @(posedge i_clk)
      if (push) mem[wr_ptr] <= s_payload;
  end
endmodule

module pzhsbus_slicer #(
  parameter int    PAYLOAD_WIDTH = 32,
  parameter int    STAGES        = 1,
  parameter string MODE          = "FULL"
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  pzhsbus_if.slave  slave_if,
  pzhsbus_if.master master_if,
  output logic      o_empty
);
  if (MODE != "FORWARD" && MODE != "BACKWARD" && MODE != "FULL") begin : g_bad_mode
    $error("pzhsbus_slicer: MODE must be FORWARD, BACKWARD or FULL");
  end
  if (STAGES == 0) begin : g_wire
    assign master_if.valid   = slave_if.valid;
    assign master_if.payload = slave_if.payload;
    assign slave_if.ready    = master_if.ready;
    assign o_empty           = 1'b1;
  end else begin : g_chain
    logic [STAGES-1:0] stage_empty;
    // per-stage link signals live in each generate block so the combinational
    // ready/valid chains never form a loop through one shared vector
    for (genvar k = 0; k < STAGES; k++) begin : g_st
      logic                     s_valid, s_ready, m_valid, m_ready;
      logic [PAYLOAD_WIDTH-1:0] s_payload, m_payload;
      if (k == 0) begin : g_head
        assign s_valid        = slave_if.valid;
        assign s_payload      = slave_if.payload;
        assign slave_if.ready = s_ready;
      end else begin : g_link
        assign s_valid   = g_st[k-1].m_valid;
        assign s_payload = g_st[k-1].m_payload;
      end
      if (k == STAGES - 1) begin : g_tail
        assign m_ready           = master_if.ready;
        assign master_if.valid   = m_valid;
        assign master_if.payload = m_payload;
      end else begin : g_next
        assign m_ready = g_st[k+1].s_ready;
      end
      pzhsbus_slicer_stage #(.W(PAYLOAD_WIDTH), .MODE(MODE)) u_stage (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .s_valid   (s_valid),
        .s_payload (s_payload),
        .s_ready   (s_ready),
        .m_valid   (m_valid),
        .m_payload (m_payload),
        .m_ready   (m_ready),
        .empty     (stage_empty[k])
      );
    end
    assign o_empty = &stage_empty;
  end
endmodule

// File: tb/tb_pzhsbus_slicer.sv
// tb_pzhsbus_slicer: directed vector table plus scoreboarded random streams for FULL, BACKWARD, FORWARD x3 and STAGES=0.
module tb_pzhsbus_slicer;
  localparam int W = 8;
  localparam int N = 1000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [3:0]   sv = '0, mr = '0;
  logic [3:0]   sr, mv, emp;
  logic [W-1:0] sd [4];
  logic [W-1:0] md [4];
  pzhsbus_if #(.PAYLOAD_WIDTH(W)) s0(), m0(), s1(), m1(), s2(), m2(), s3(), m3();
  assign s0.valid = sv[0]; assign s0.payload = sd[0]; assign m0.ready = mr[0];
  assign s1.valid = sv[1]; assign s1.payload = sd[1]; assign m1.ready = mr[1];
  assign s2.valid = sv[2]; assign s2.payload = sd[2]; assign m2.ready = mr[2];
  assign s3.valid = sv[3]; assign s3.payload = sd[3]; assign m3.ready = mr[3];
  assign sr = {s3.ready, s2.ready, s1.ready, s0.ready};
  assign mv = {m3.valid, m2.valid, m1.valid, m0.valid};
  assign md[0] = m0.payload; assign md[1] = m1.payload;
  assign md[2] = m2.payload; assign md[3] = m3.payload;
  pzhsbus_slicer #(.PAYLOAD_WIDTH(W), .STAGES(1), .MODE("FULL")) u_full (
    .i_clk(clk), .i_rst_n(rst_n), .slave_if(s0), .master_if(m0), .o_empty(emp[0]));
  pzhsbus_slicer #(.PAYLOAD_WIDTH(W), .STAGES(1), .MODE("BACKWARD")) u_bwd (
    .i_clk(clk), .i_rst_n(rst_n), .slave_if(s1), .master_if(m1), .o_empty(emp[1]));
  pzhsbus_slicer #(.PAYLOAD_WIDTH(W), .STAGES(3), .MODE("FORWARD")) u_fwd (
    .i_clk(clk), .i_rst_n(rst_n), .slave_if(s2), .master_if(m2), .o_empty(emp[2]));
  pzhsbus_slicer #(.PAYLOAD_WIDTH(W), .STAGES(0), .MODE("FULL")) u_wire (
    .i_clk(clk), .i_rst_n(rst_n), .slave_if(s3), .master_if(m3), .o_empty(emp[3]));
  typedef struct {
    int         sel;
    logic       sv;
    logic [7:0] d;
    logic       mr;
    logic       sr;
    logic       mv;
    logic [7:0] md;
    logic       e;
  } vec_t;
  vec_t       tbl [$];
  vec_t       t;
  int         n_chk = 0, n_err = 0;
  logic [7:0] qd [3][$];
  int         qc [3][$];
  int         pushed [3], popped [3];
  int         minlat [3];
  int         c, lat;
  logic [7:0] exp_d;
  bit         done;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  initial begin
    // sel: 0 FULL, 1 BACKWARD, 3 STAGES=0; fields sv d mr | sr mv md e
    tbl.push_back('{0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1});
    tbl.push_back('{0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0});
    tbl.push_back('{0, 1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h02, 1'b0});
    tbl.push_back('{0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0});
    tbl.push_back('{0, 1'b1, 8'h0A, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1});
    tbl.push_back('{0, 1'b1, 8'h0B, 1'b0, 1'b1, 1'b1, 8'h0A, 1'b0});
    tbl.push_back('{0, 1'b1, 8'h0C, 1'b0, 1'b0, 1'b1, 8'h0A, 1'b0});
    tbl.push_back('{0, 1'b0, 8'h0C, 1'b0, 1'b0, 1'b1, 8'h0A, 1'b0});
    tbl.push_back('{0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h0A, 1'b0});
    tbl.push_back('{0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h0B, 1'b0});
    tbl.push_back('{0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1});
    tbl.push_back('{1, 1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 8'h04, 1'b1});
    tbl.push_back('{1, 1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 8'h05, 1'b1});
    tbl.push_back('{1, 1'b1, 8'h06, 1'b0, 1'b0, 1'b1, 8'h05, 1'b0});
    tbl.push_back('{1, 1'b0, 8'h06, 1'b0, 1'b0, 1'b1, 8'h05, 1'b0});
    tbl.push_back('{1, 1'b1, 8'h06, 1'b1, 1'b0, 1'b1, 8'h05, 1'b0});
    tbl.push_back('{1, 1'b1, 8'h06, 1'b1, 1'b1, 1'b1, 8'h06, 1'b1});
    tbl.push_back('{1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1});
    tbl.push_back('{3, 1'b1, 8'h09, 1'b0, 1'b0, 1'b1, 8'h09, 1'b1});
    tbl.push_back('{3, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1});
    tbl.push_back('{3, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b1});
    minlat = '{1, 0, 3};
    for (int i = 0; i < 4; i++) sd[i] = '0;
    // reset state
    #12;
    check("rst full sready", sr[0], 1);
    check("rst full mvalid", mv[0], 0);
    check("rst full empty", emp[0], 1);
    check("rst bwd sready", sr[1], 1);
    check("rst bwd empty", emp[1], 1);
    check("rst fwd mvalid", mv[2], 0);
    check("rst fwd empty", emp[2], 1);
    check("rst fwd sready", sr[2], 1);
    @(negedge clk);
    rst_n = 1'b1;
    // directed vector table
    foreach (tbl[j]) begin
      t = tbl[j];
      @(negedge clk);
      sv = '0;
      mr = '0;
      sv[t.sel] = t.sv;
      sd[t.sel] = t.d;
      mr[t.sel] = t.mr;
      #1;
      check($sformatf("row%0d sready", j), sr[t.sel], t.sr);
      check($sformatf("row%0d mvalid", j), mv[t.sel], t.mv);
      check($sformatf("row%0d empty", j), emp[t.sel], t.e);
      if (t.mv) check($sformatf("row%0d payload", j), md[t.sel], t.md);
    end
    // FULL holding two entries, reset mid-transfer
    @(negedge clk);
    sv = '0; mr = '0;
    sv[0] = 1'b1; sd[0] = 8'h11;
    @(negedge clk);
    sd[0] = 8'h22;
    @(negedge clk);
    sv[0] = 1'b0;
    #1;
    check("hold2 sready", sr[0], 0);
    check("hold2 mvalid", mv[0], 1);
    check("hold2 payload", md[0], 8'h11);
    check("hold2 empty", emp[0], 0);
    #1 rst_n = 1'b0;
    #1;
    check("midrst mvalid", mv[0], 0);
    check("midrst empty", emp[0], 1);
    check("midrst sready", sr[0], 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sv[0] = 1'b1; sd[0] = 8'h07; mr[0] = 1'b1;
    #1;
    check("postrst idle mvalid", mv[0], 0);
    @(negedge clk);
    sv[0] = 1'b0;
    #1;
    check("postrst first mvalid", mv[0], 1);
    check("postrst first payload", md[0], 8'h07);
    @(negedge clk);
    #1;
    check("postrst drained mvalid", mv[0], 0);
    check("postrst drained empty", emp[0], 1);
    // random streams with scoreboards; STAGES=0 mirrored each cycle
    for (int i = 0; i < 3; i++) begin pushed[i] = 0; popped[i] = 0; end
    done = 1'b0;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        sv[i] = (i == 3 || pushed[i] < N) && ($urandom_range(0, 3) != 0);
        sd[i] = (i == 3) ? 8'($urandom) : 8'(pushed[i]);
        mr[i] = $urandom_range(0, 3) != 0;
      end
      #1;
      check("wire valid", mv[3], sv[3]);
      check("wire payload", md[3], sd[3]);
      check("wire ready", sr[3], mr[3]);
      for (int i = 0; i < 3; i++) begin
        if (sv[i] && sr[i]) begin
          qd[i].push_back(sd[i]);
          qc[i].push_back(cyc);
          pushed[i]++;
        end
        if (mv[i] && mr[i]) begin
          if (qd[i].size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL dut%0d spurious output %0h, expected none", i, md[i]);
          end else begin
            exp_d = qd[i].pop_front();
            c = qc[i].pop_front();
            check($sformatf("dut%0d stream payload", i), md[i], exp_d);
            lat = cyc - c;
            n_chk++;
            if (lat < minlat[i]) begin
              n_err++;
              $display("FAIL dut%0d latency got %0d expected >= %0d", i, lat, minlat[i]);
            end
          end
          popped[i]++;
        end
      end
      done = 1'b1;
      for (int i = 0; i < 3; i++) if (pushed[i] < N || popped[i] < N) done = 1'b0;
    end
    check("stream finished", done, 1);
    @(negedge clk);
    sv = '0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("dut%0d popped", i), popped[i], N);
      check($sformatf("dut%0d drain empty", i), emp[i], 1);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
